spi_serf_regs: RTL

SPI_SERF_REGS -- requirements
Module: spi_serf_regs

---
 rtl/spi_serf_regs.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/spi_serf_regs.sv
// SPI-mode-0 register slave for a yaw-rate sensor front end: CDC synchronizers, frame FSM, register map.
// Define SPI_SERF_INT_EN to include the data-ready flag and the INT output; otherwise INT is tied low.
module spi_serf_regs #(
    parameter logic [7:0] WHO_AM_I_VAL = 8'h6A,
    parameter int         SMPL_EN_REQ  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               SS_n,
    input  logic               SCLK,
    input  logic               MOSI,
    output logic               MISO,
    output logic               INT,
    input  logic signed [15:0] yaw_rate,
    input  logic               smpl_vld,
    output logic               frm_done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CMD  = 2'd1;
    localparam logic [1:0] DATA = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [2:0] ss_q, sclk_q;
    logic [1:0] mosi_q;
    logic       ss_rise, ss_fall, sclk_rise, sclk_fall, mosi_s;

    logic [1:0]         state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [15:0]        rx_q, rx_d;
    logic [7:0]         tx_q, tx_d;
    logic               miso_q, miso_d;
    logic               frm_q, frm_d;
    logic [7:0]         shadow_q, shadow_d;
    logic [7:0]         int1_q, int1_d;
    logic [7:0]         ctrl2_q, ctrl2_d;
    logic signed [15:0] outz_q, outz_d;
    logic [6:0]         rd_addr;
    logic [7:0]         rd_byte;
    logic               smpl_en;

    // Synchronizers are left out of reset so a select held low through reset never looks like a fresh fall.
    always_ff @(posedge clk) begin
        ss_q   <= {ss_q[1:0], SS_n};
        sclk_q <= {sclk_q[1:0], SCLK};
        mosi_q <= {mosi_q[0], MOSI};
    end

    assign ss_rise   =  ss_q[1] & ~ss_q[2];
    assign ss_fall   = ~ss_q[1] &  ss_q[2];
    assign sclk_rise =  sclk_q[1] & ~sclk_q[2];
    assign sclk_fall = ~sclk_q[1] &  sclk_q[2];
    assign mosi_s    = mosi_q[1];
    assign rd_addr   = {rx_q[5:0], mosi_s};
    assign smpl_en   = (SMPL_EN_REQ != 0) ? (ctrl2_q != 8'h00) : 1'b1;

    always_comb begin
        rd_byte = 8'h00;
        case (rd_addr)
            7'h0D:   rd_byte = int1_q;
            7'h0F:   rd_byte = WHO_AM_I_VAL;
            7'h11:   rd_byte = ctrl2_q;
            7'h26:   rd_byte = outz_q[7:0];
            7'h27:   rd_byte = shadow_q;
            default: rd_byte = 8'h00;
        endcase
    end

`ifdef SPI_SERF_INT_EN
    logic drdy_q, drdy_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rx_d     = rx_q;
        tx_d     = tx_q;
        miso_d   = miso_q;
        frm_d    = 1'b0;
        shadow_d = shadow_q;
        int1_d   = int1_q;
        ctrl2_d  = ctrl2_q;
        outz_d   = outz_q;
`ifdef SPI_SERF_INT_EN
        drdy_d   = drdy_q;
`endif
        case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d = CMD;
                    cnt_d   = 5'd0;
                    tx_d    = 8'h00;
                end
            end
            CMD: begin
                if (ss_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d  = {rx_q[14:0], mosi_s};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd7) begin
                        state_d = DATA;
                        // rx_q[6] is the R/W bit once the 8th bit arrives
                        if (rx_q[6]) begin
                            tx_d = rd_byte;
                            if (rd_addr == 7'h26) shadow_d = outz_q[15:8];
                        end
                    end
                end
            end
            DATA: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else if (sclk_rise) begin
                    rx_d  = {rx_q[14:0], mosi_s};
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd15) state_d = DONE;
                end else if (sclk_fall) begin
                    miso_d = tx_q[7];
                    tx_d   = {tx_q[6:0], 1'b0};
                end
            end
            default: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                    frm_d   = 1'b1;
                    if (!rx_q[15]) begin
                        if (rx_q[14:8] == 7'h0D) int1_d  = rx_q[7:0];
                        if (rx_q[14:8] == 7'h11) ctrl2_d = rx_q[7:0];
                    end
`ifdef SPI_SERF_INT_EN
                    else if (rx_q[14:8] == 7'h27) drdy_d = 1'b0;
`endif
                end
            end
        endcase
        // Capture comes last so a new sample beats a same-cycle clear-on-read.
        if (smpl_vld && smpl_en) begin
            outz_d = yaw_rate;
`ifdef SPI_SERF_INT_EN
            drdy_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        rx_q <= rx_d;
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            tx_q     <= 8'h00;
            miso_q   <= 1'b0;
            frm_q    <= 1'b0;
            shadow_q <= 8'h00;
            int1_q   <= 8'h00;
            ctrl2_q  <= 8'h00;
            outz_q   <= 16'sd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tx_q     <= tx_d;
            miso_q   <= miso_d;
            frm_q    <= frm_d;
            shadow_q <= shadow_d;
            int1_q   <= int1_d;
            ctrl2_q  <= ctrl2_d;
            outz_q   <= outz_d;
        end
    end

`ifdef SPI_SERF_INT_EN
    always_ff @(posedge clk) begin
        if (rst) drdy_q <= 1'b0;
        else     drdy_q <= drdy_d;
    end
    assign INT = drdy_q & int1_q[1];
`else
    assign INT = 1'b0;
`endif

    assign MISO     = miso_q;
    assign frm_done = frm_q;

endmodule
